// File: rtl/hazard_unit_if.sv
// Decode-side bundle for hazard_unit: ID/EX hazard inputs, branch operands,
// MDU issue, and the stall/flush/write-enable controls back to the pipeline.
interface hazard_unit_if #(
  parameter int DATA_W = 32,
  parameter int AW     = 5
);
  logic              id_ex_memread_i;
  logic [AW-1:0]     id_ex_rd_i;
  logic [AW-1:0]     if_id_rs_i;
  logic [AW-1:0]     if_id_rt_i;
  logic              use_rt_i;
  logic [DATA_W-1:0] rs_data_i;
  logic [DATA_W-1:0] rt_data_i;
  logic              branch_i;
  logic              bne_i;
  logic              mdu_start_i;
  logic [AW-1:0]     mdu_rd_i;

  logic              ctrl_sel_o;
  logic              pc_write_o;
  logic              if_id_write_o;
  logic              stall_o;
  logic              flush_o;
  logic              mdu_busy_o;
  logic [15:0]       stall_cnt_o;
  logic [15:0]       flush_cnt_o;

  modport master (
    output id_ex_memread_i, id_ex_rd_i, if_id_rs_i, if_id_rt_i, use_rt_i,
           rs_data_i, rt_data_i, branch_i, bne_i, mdu_start_i, mdu_rd_i,
    input  ctrl_sel_o, pc_write_o, if_id_write_o, stall_o, flush_o,
           mdu_busy_o, stall_cnt_o, flush_cnt_o
  );

  modport slave (
    input  id_ex_memread_i, id_ex_rd_i, if_id_rs_i, if_id_rt_i, use_rt_i,
           rs_data_i, rt_data_i, branch_i, bne_i, mdu_start_i, mdu_rd_i,
    output ctrl_sel_o, pc_write_o, if_id_write_o, stall_o, flush_o,
           mdu_busy_o, stall_cnt_o, flush_cnt_o
  );
endinterface

// File: rtl/hazard_unit.sv
// Pipeline hazard controller: multi-cycle load-use stalls, single-entry MDU
// scoreboard, ID-stage BEQ/BNE flush. Define HAZARD_STATS_EN for stall/flush counters.
module hazard_unit #(
  parameter int DATA_W     = 32,
  parameter int AW         = 5,
  parameter int LOAD_STALL = 1,
  parameter int MDU_LAT    = 4
) (
  input  logic         clk_i,
  input  logic         rst_i,
  hazard_unit_if.slave bus
);

  logic [2:0]        ld_cnt;
  logic [3:0]        mdu_cnt;
  logic [AW-1:0]     mdu_rd;
  logic [DATA_W-1:0] rs_d, rt_d;
  logic              lh, mh, busy, hazard, taken, issue;

  assign rs_d = bus.rs_data_i;
  assign rt_d = bus.rt_data_i;

  always_comb begin
    lh = bus.id_ex_memread_i && (bus.id_ex_rd_i != '0) &&
         ((bus.id_ex_rd_i == bus.if_id_rs_i) ||
          (bus.use_rt_i && (bus.id_ex_rd_i == bus.if_id_rt_i)));
  end

  assign busy = (mdu_cnt != 4'd0);

  // A busy MDU blocks both its dependents and any new MDU issue.
  always_comb begin
    mh = busy && (((mdu_rd != '0) &&
                   ((bus.if_id_rs_i == mdu_rd) ||
                    (bus.use_rt_i && (bus.if_id_rt_i == mdu_rd)))) ||
                  bus.mdu_start_i);
  end

  assign hazard = (ld_cnt != 3'd0) || lh || mh;
  assign taken  = (rs_d == rt_d) ^ bus.bne_i;
  assign issue  = bus.mdu_start_i && !hazard && !bus.branch_i;

  assign bus.stall_o       = !rst_i && hazard;
  assign bus.flush_o       = !rst_i && bus.branch_i && !hazard && taken;
  assign bus.ctrl_sel_o    = !bus.stall_o;
  assign bus.pc_write_o    = !bus.stall_o;
  assign bus.if_id_write_o = !bus.stall_o;
  assign bus.mdu_busy_o    = busy;

  // The first bubble comes from lh itself; ld_cnt covers the remaining ones.
  generate
    if (LOAD_STALL > 1) begin : g_ld
      always_ff @(posedge clk_i) begin
        if (rst_i)
          ld_cnt <= 3'd0;
        else if (ld_cnt != 3'd0)
          ld_cnt <= ld_cnt - 3'd1;
        else if (lh)
          ld_cnt <= 3'(LOAD_STALL - 1);
      end
    end else begin : g_no_ld
      assign ld_cnt = 3'd0;
    end
  endgenerate

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mdu_cnt <= 4'd0;
      mdu_rd  <= '0;
    end else if (issue) begin
      mdu_cnt <= 4'(MDU_LAT);
      mdu_rd  <= bus.mdu_rd_i;
    end else if (busy) begin
      mdu_cnt <= mdu_cnt - 4'd1;
    end
  end

`ifdef HAZARD_STATS_EN
  logic [15:0] stall_cnt, flush_cnt;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_cnt <= 16'd0;
      flush_cnt <= 16'd0;
    end else begin
      if (bus.stall_o && (stall_cnt != 16'hFFFF)) stall_cnt <= stall_cnt + 16'd1;
      if (bus.flush_o && (flush_cnt != 16'hFFFF)) flush_cnt <= flush_cnt + 16'd1;
    end
  end

  assign bus.stall_cnt_o = stall_cnt;
  assign bus.flush_cnt_o = flush_cnt;
`else
  assign bus.stall_cnt_o = 16'd0;
  assign bus.flush_cnt_o = 16'd0;
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// Bench for hazard_unit: LOAD_STALL=1 and LOAD_STALL=3 instances share stimulus
// and are checked each cycle against a cycle-timestamp reference model.
module tb_hazard_unit;
  localparam int DW  = 32;
  localparam int AW  = 5;
  localparam int MDU = 4;
`ifdef HAZARD_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  hazard_unit_if #(.DATA_W(DW), .AW(AW)) if1 ();
  hazard_unit_if #(.DATA_W(DW), .AW(AW)) if3 ();

  assign if1.id_ex_memread_i = if3.id_ex_memread_i;
  assign if1.id_ex_rd_i      = if3.id_ex_rd_i;
  assign if1.if_id_rs_i      = if3.if_id_rs_i;
  assign if1.if_id_rt_i      = if3.if_id_rt_i;
  assign if1.use_rt_i        = if3.use_rt_i;
  assign if1.rs_data_i       = if3.rs_data_i;
  assign if1.rt_data_i       = if3.rt_data_i;
  assign if1.branch_i        = if3.branch_i;
  assign if1.bne_i           = if3.bne_i;
  assign if1.mdu_start_i     = if3.mdu_start_i;
  assign if1.mdu_rd_i        = if3.mdu_rd_i;

  hazard_unit #(.DATA_W(DW), .AW(AW), .LOAD_STALL(1), .MDU_LAT(MDU)) dut1 (
    .clk_i(clk), .rst_i(rst), .bus(if1.slave));
  hazard_unit #(.DATA_W(DW), .AW(AW), .LOAD_STALL(3), .MDU_LAT(MDU)) dut3 (
    .clk_i(clk), .rst_i(rst), .bus(if3.slave));

  int n_chk, n_pass, cyc;
  // Model state: absolute cycle numbers instead of down-counters.
  int ld_until [2];
  int mdu_done [2];
  logic [AW-1:0] mrd_m [2];
  int scnt [2];
  int fcnt [2];
  // {stall, ctrl_sel, pc_write, if_id_write, flush, busy}
  logic [5:0] last1, last3;

  task automatic chk(input string name, input int k, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s L=%0d cyc=%0d got=%0h exp=%0h", name, (k == 0) ? 1 : 3, cyc, got, exp);
  endtask

  task automatic drive(input logic mr, input logic [AW-1:0] exrd, input logic [AW-1:0] rs,
                       input logic [AW-1:0] rt, input logic urt, input logic [DW-1:0] rsd,
                       input logic [DW-1:0] rtd, input logic br, input logic bne,
                       input logic ms, input logic [AW-1:0] mrd);
    if3.id_ex_memread_i = mr;  if3.id_ex_rd_i = exrd;
    if3.if_id_rs_i = rs;       if3.if_id_rt_i = rt;    if3.use_rt_i = urt;
    if3.rs_data_i = rsd;       if3.rt_data_i = rtd;
    if3.branch_i = br;         if3.bne_i = bne;
    if3.mdu_start_i = ms;      if3.mdu_rd_i = mrd;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic step(input string tag);
    logic resid, lh, busy, mh, haz, stall, flush;
    logic [5:0] exp, got;
    logic [15:0] gs, gf;
    int es, ef;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      resid = (cyc <= ld_until[k]);
      lh = if3.id_ex_memread_i && (if3.id_ex_rd_i != 0) &&
           ((if3.id_ex_rd_i == if3.if_id_rs_i) || (if3.use_rt_i && (if3.id_ex_rd_i == if3.if_id_rt_i)));
      busy = (cyc < mdu_done[k]);
      mh = busy && (((mrd_m[k] != 0) && ((if3.if_id_rs_i == mrd_m[k]) ||
                     (if3.use_rt_i && (if3.if_id_rt_i == mrd_m[k])))) || if3.mdu_start_i);
      haz = resid || lh || mh;
      stall = !rst && haz;
      flush = !rst && if3.branch_i && !haz && ((if3.rs_data_i == if3.rt_data_i) != if3.bne_i);
      exp = {stall, !stall, !stall, !stall, flush, busy};
      if (k == 0) begin
        got = {if1.stall_o, if1.ctrl_sel_o, if1.pc_write_o, if1.if_id_write_o, if1.flush_o, if1.mdu_busy_o};
        gs = if1.stall_cnt_o; gf = if1.flush_cnt_o; last1 = got;
      end else begin
        got = {if3.stall_o, if3.ctrl_sel_o, if3.pc_write_o, if3.if_id_write_o, if3.flush_o, if3.mdu_busy_o};
        gs = if3.stall_cnt_o; gf = if3.flush_cnt_o; last3 = got;
      end
      es = STATS ? scnt[k] : 0;
      ef = STATS ? fcnt[k] : 0;
      chk({tag, "_ctl"}, k, 64'(got), 64'(exp));
      chk({tag, "_cnt"}, k, {gs, gf}, {16'(es), 16'(ef)});
      if (rst) begin
        ld_until[k] = -1; mdu_done[k] = 0; mrd_m[k] = '0; scnt[k] = 0; fcnt[k] = 0;
      end else begin
        if (!resid && lh) ld_until[k] = cyc + ((k == 0) ? 1 : 3) - 1;
        if (if3.mdu_start_i && !stall && !if3.branch_i) begin
          mdu_done[k] = cyc + 1 + MDU;
          mrd_m[k] = if3.mdu_rd_i;
        end
        if (stall && scnt[k] < 65535) scnt[k]++;
        if (flush && fcnt[k] < 65535) fcnt[k]++;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  typedef struct {
    logic mr; logic [AW-1:0] exrd, rs, rt; logic urt;
    logic [DW-1:0] rsd, rtd; logic br, bne;
    logic e_stall, e_flush;
  } vec_t;

  vec_t vt [10];
  logic [5:0] s1, s3, b1, b3;

  initial begin
    n_chk = 0; n_pass = 0; cyc = 0;
    for (int k = 0; k < 2; k++) begin
      ld_until[k] = -1; mdu_done[k] = 0; mrd_m[k] = '0; scnt[k] = 0; fcnt[k] = 0;
    end

    vt[0] = '{1, 5, 5, 0, 0, 0, 0, 0, 0, 1, 0};
    vt[1] = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    vt[2] = '{1, 7, 1, 7, 1, 0, 0, 0, 0, 1, 0};
    vt[3] = '{1, 7, 1, 7, 0, 0, 0, 0, 0, 0, 0};
    vt[4] = '{0, 0, 0, 0, 0, 32'h1234, 32'h1234, 1, 0, 0, 1};
    vt[5] = '{0, 0, 0, 0, 0, 32'h1234, 32'h1234, 1, 1, 0, 0};
    vt[6] = '{0, 0, 0, 0, 0, 1, 2, 1, 1, 0, 1};
    vt[7] = '{0, 0, 0, 0, 0, 1, 2, 1, 0, 0, 0};
    vt[8] = '{1, 5, 5, 0, 0, 32'h1234, 32'h1234, 1, 0, 1, 0};
    vt[9] = '{0, 5, 5, 0, 0, 0, 0, 0, 0, 0, 0};

    rst = 1; idle();
    step("rst"); step("rst");
    rst = 0;
    step("idle");
    chk("reset_idle", 0, 64'(last1), 64'(6'b011100));
    chk("reset_idle", 1, 64'(last3), 64'(6'b011100));

    // Single-cycle combinational cases against the LOAD_STALL=1 instance.
    for (int i = 0; i < 10; i++) begin
      drive(vt[i].mr, vt[i].exrd, vt[i].rs, vt[i].rt, vt[i].urt,
            vt[i].rsd, vt[i].rtd, vt[i].br, vt[i].bne, 0, 0);
      step("vec");
      chk($sformatf("vec%0d_stall", i), 0, 64'(last1[5]), 64'(vt[i].e_stall));
      chk($sformatf("vec%0d_flush", i), 0, 64'(last1[1]), 64'(vt[i].e_flush));
    end

    // Load-use through rt: one-cycle hazard then load gone.
    idle(); repeat (4) step("gap");
    s1 = 0; s3 = 0;
    drive(1, 7, 0, 7, 1, 0, 0, 0, 0, 0, 0); step("ld_rt");
    s1 = {s1[4:0], last1[5]}; s3 = {s3[4:0], last3[5]};
    idle();
    repeat (3) begin step("ld_rt"); s1 = {s1[4:0], last1[5]}; s3 = {s3[4:0], last3[5]}; end
    chk("ld3_stall_seq", 1, 64'(s3[3:0]), 64'(4'b1110));
    chk("ld1_stall_seq", 0, 64'(s1[3:0]), 64'(4'b1000));
    s1 = 0; s3 = 0;
    drive(1, 7, 0, 7, 0, 0, 0, 0, 0, 0, 0); step("ld_nort");
    s1 = {s1[4:0], last1[5]}; s3 = {s3[4:0], last3[5]};
    idle();
    repeat (3) begin step("ld_nort"); s1 = {s1[4:0], last1[5]}; s3 = {s3[4:0], last3[5]}; end
    chk("ld_nort_stall", 1, 64'(s3[3:0]), 64'(4'b0000));
    chk("ld_nort_stall", 0, 64'(s1[3:0]), 64'(4'b0000));

    // MDU dependency: issue rd=9, then consumer of r9.
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 9); step("mdu_iss");
    drive(0, 0, 9, 0, 0, 0, 0, 0, 0, 0, 0);
    s3 = 0; b3 = 0; s1 = 0; b1 = 0;
    repeat (6) begin
      step("mdu_dep");
      s3 = {s3[4:0], last3[5]}; b3 = {b3[4:0], last3[0]};
      s1 = {s1[4:0], last1[5]}; b1 = {b1[4:0], last1[0]};
    end
    chk("mdu_busy_seq", 1, 64'(b3), 64'(6'b111100));
    chk("mdu_stall_seq", 1, 64'(s3), 64'(6'b111100));
    chk("mdu_busy_seq", 0, 64'(b1), 64'(6'b111100));
    chk("mdu_stall_seq", 0, 64'(s1), 64'(6'b111100));

    // Second MDU op held from cycle 2 waits for busy to clear.
    idle(); repeat (2) step("gap");
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 9); step("mdu_a");
    idle(); step("mdu_c1");
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 10);
    s3 = 0;
    repeat (4) begin step("mdu_b"); s3 = {s3[4:0], last3[5]}; end
    chk("mdu2_stall_seq", 1, 64'(s3[3:0]), 64'(4'b1110));
    idle(); step("mdu_b_busy");
    chk("mdu2_busy", 1, 64'(last3[0]), 64'(1'b1));
    repeat (6) step("gap");

    // Taken branch behind a load-use hazard.
    drive(1, 5, 5, 0, 0, 0, 0, 1, 0, 0, 0); step("br_lh");
    s1 = {5'd0, last1[1]}; s3 = {5'd0, last3[1]};
    drive(0, 5, 5, 0, 0, 0, 0, 1, 0, 0, 0);
    repeat (3) begin step("br_lh"); s1 = {s1[4:0], last1[1]}; s3 = {s3[4:0], last3[1]}; end
    chk("br_lh_flush", 1, 64'(s3[3:0]), 64'(4'b0001));
    chk("br_lh_flush", 0, 64'(s1[3:0]), 64'(4'b0111));
    idle(); repeat (3) step("gap");

    // Reset in the middle of a load stall.
    drive(1, 7, 0, 7, 1, 0, 0, 0, 0, 0, 0); step("rst_ld");
    rst = 1; idle(); step("rst_ld_rst");
    rst = 0; step("rst_ld_after");
    chk("rst_ld_stall", 1, 64'(last3[5]), 64'(1'b0));
    // Reset with mdu_cnt == 2.
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 9); step("rst_mdu");
    drive(0, 0, 9, 0, 0, 0, 0, 0, 0, 0, 0);
    step("rst_mdu"); step("rst_mdu");
    rst = 1; step("rst_mdu_rst");
    rst = 0; step("rst_mdu_after");
    chk("rst_mdu_busy", 1, 64'(last3[0]), 64'(1'b0));
    chk("rst_mdu_stall", 1, 64'(last3[5]), 64'(1'b0));

    // Stats: 5 stall cycles and 2 flushes on the LOAD_STALL=1 instance.
    rst = 1; idle(); step("st_rst");
    rst = 0;
    drive(1, 5, 5, 0, 0, 0, 0, 0, 0, 0, 0); repeat (5) step("st_stall");
    idle(); repeat (3) step("st_gap");
    drive(0, 0, 0, 0, 0, 3, 3, 1, 0, 0, 0); repeat (2) step("st_flush");
    idle(); step("st_end");
    chk("stats_stall_cnt", 0, 64'(if1.stall_cnt_o), STATS ? 64'd5 : 64'd0);
    chk("stats_flush_cnt", 0, 64'(if1.flush_cnt_o), STATS ? 64'd2 : 64'd0);
`ifdef HAZARD_STATS_EN
    drive(1, 5, 5, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (70000) step("st_sat");
    idle(); step("st_sat_end");
    chk("stats_sat", 0, 64'(if1.stall_cnt_o), 64'hFFFF);
    chk("stats_sat", 1, 64'(if3.stall_cnt_o), 64'hFFFF);
`endif

    // Randomized traffic against the model.
    for (int i = 0; i < 2000; i++) begin
      rst = ($urandom_range(0, 60) == 0);
      drive($urandom_range(0, 2) == 0, AW'($urandom_range(0, 3)), AW'($urandom_range(0, 3)),
            AW'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            DW'($urandom_range(0, 1)), DW'($urandom_range(0, 1)),
            $urandom_range(0, 3) == 0, 1'($urandom_range(0, 1)),
            $urandom_range(0, 5) == 0, AW'($urandom_range(0, 3)));
      step("rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
